// File: rtl/my_pkg.sv
// Shared mesh geometry and enums for the NoC statistics collector.
package my_pkg;

  localparam int MESH_SIZE = 4;
  localparam int PE_NUMBER = MESH_SIZE * MESH_SIZE;

  typedef enum logic [1:0] {
    STAT_STALL    = 2'd0,
    STAT_CONFLICT = 2'd1,
    STAT_FINISH   = 2'd2,
    STAT_TOTAL    = 2'd3
  } stats_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } stats_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (inc && !(&r_q)) begin
      r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/noc_stats_unit.sv
// Per-PE stall/conflict/finish statistics and layer cycle count with a 1-cycle read port.
// Conflict counters are built only when NOC_STATS_CONFLICT_EN is defined.
module noc_stats_unit
  import my_pkg::*;
#(
  parameter int MESH_SIZE = my_pkg::MESH_SIZE,
  parameter int CNT_W     = 32,
  localparam int PE_N     = MESH_SIZE * MESH_SIZE,
  localparam int IDX_W    = (PE_N > 1) ? $clog2(PE_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PE_N-1:0]   pe_stall,
  input  logic [PE_N-1:0]   router_conflict,
  input  logic [PE_N-1:0]   pe_done,
  input  logic              layer_finished,
  input  logic              rd_req,
  input  logic [1:0]        rd_sel,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic              measuring,
  output logic              stats_ready
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  stats_state_t     r_state;
  logic             r_measuring;
  logic             r_stats_ready;
  logic [PE_N-1:0]  r_fin_flag;
  logic [CNT_W-1:0] r_fin_cyc [PE_N];
  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_err;

  logic             w_run;
  logic [CNT_W-1:0] w_cycle_q;
  logic [CNT_W-1:0] w_stall_q [PE_N];
  logic [CNT_W-1:0] w_rd_data;
  logic             w_rd_err;
  logic             w_in_range;

  // A start in RUN clears rather than counts, so it is excluded here.
  assign w_run = (r_state == ST_RUN) && !start;

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk (clk), .rst (rst), .clr (start), .inc (w_run), .q (w_cycle_q)
  );

  for (genvar i = 0; i < PE_N; i++) begin : g_stall
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk), .rst (rst), .clr (start), .inc (w_run & pe_stall[i]), .q (w_stall_q[i])
    );
  end

`ifdef NOC_STATS_CONFLICT_EN
  logic [CNT_W-1:0] w_conf_q [PE_N];

  for (genvar i = 0; i < PE_N; i++) begin : g_conf
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk), .rst (rst), .clr (start), .inc (w_run & router_conflict[i]), .q (w_conf_q[i])
    );
  end
`else
  logic w_unused_conf;
  assign w_unused_conf = ^router_conflict;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_measuring   <= 1'b0;
      r_stats_ready <= 1'b0;
    end else if (start) begin
      r_state       <= ST_RUN;
      r_measuring   <= 1'b1;
      r_stats_ready <= 1'b0;
    end else if (r_state == ST_RUN && layer_finished) begin
      r_state       <= ST_HOLD;
      r_measuring   <= 1'b0;
      r_stats_ready <= 1'b1;
    end
  end

  // Finish cycle is the 1-based RUN cycle; unfinished PEs take the final cycle.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_fin_flag <= '0;
      for (int i = 0; i < PE_N; i++) r_fin_cyc[i] <= '0;
    end else if (w_run) begin
      for (int i = 0; i < PE_N; i++) begin
        if (!r_fin_flag[i] && (pe_done[i] || layer_finished)) begin
          r_fin_flag[i] <= 1'b1;
          r_fin_cyc[i]  <= sat_inc(w_cycle_q);
        end
      end
    end
  end

  assign w_in_range = (int'(rd_idx) < PE_N);

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (stats_sel_t'(rd_sel))
      STAT_TOTAL: w_rd_data = w_cycle_q;
      STAT_STALL: begin
        if (w_in_range) w_rd_data = w_stall_q[rd_idx];
        else            w_rd_err  = 1'b1;
      end
      STAT_FINISH: begin
        if (w_in_range) w_rd_data = r_fin_cyc[rd_idx];
        else            w_rd_err  = 1'b1;
      end
      default: begin
`ifdef NOC_STATS_CONFLICT_EN
        if (w_in_range) w_rd_data = w_conf_q[rd_idx];
        else            w_rd_err  = 1'b1;
`else
        w_rd_err = 1'b1;
`endif
      end
    endcase
  end

  // Response register: data/err hold between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_data;
        r_rd_err  <= w_rd_err;
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_err      = r_rd_err;
  assign measuring   = r_measuring;
  assign stats_ready = r_stats_ready;

endmodule

// File: tb/tb_noc_stats_unit.sv
// Randomized and directed bench for noc_stats_unit against a cycle-level behavioural model.
module tb_noc_stats_unit;

  localparam int MS   = 3;
  localparam int PE   = MS * MS;
  localparam int CW   = 4;
  localparam int IW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [PE-1:0] pe_stall = '0;
  logic [PE-1:0] router_conflict = '0;
  logic [PE-1:0] pe_done = '0;
  logic          layer_finished = 1'b0;
  logic          rd_req = 1'b0;
  logic [1:0]    rd_sel = '0;
  logic [IW-1:0] rd_idx = '0;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic          rd_err;
  logic          measuring;
  logic          stats_ready;

  noc_stats_unit #(.MESH_SIZE(MS), .CNT_W(CW)) dut (
    .clk (clk), .rst (rst), .start (start), .pe_stall (pe_stall),
    .router_conflict (router_conflict), .pe_done (pe_done),
    .layer_finished (layer_finished), .rd_req (rd_req), .rd_sel (rd_sel),
    .rd_idx (rd_idx), .rd_valid (rd_valid), .rd_data (rd_data), .rd_err (rd_err),
    .measuring (measuring), .stats_ready (stats_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 idle, 1 measuring, 2 holding results
  int m_phase;
  int m_cyc;
  int m_stall [PE];
  int m_conf  [PE];
  int m_fin   [PE];
  bit m_done_seen [PE];
  int m_valid, m_data, m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_clear();
    m_cyc = 0;
    for (int i = 0; i < PE; i++) begin
      m_stall[i] = 0; m_conf[i] = 0; m_fin[i] = 0; m_done_seen[i] = 0;
    end
  endtask

  task automatic model_read(input int sel, input int idx, output int d, output int e);
    d = 0; e = 0;
    if (sel == 3) d = m_cyc;
    else if (idx >= PE) e = 1;
    else if (sel == 0) d = m_stall[idx];
    else if (sel == 2) d = m_fin[idx];
    else begin
`ifdef NOC_STATS_CONFLICT_EN
      d = m_conf[idx];
`else
      e = 1;
`endif
    end
  endtask

  task automatic model_step();
    int d, e;
    if (rst) begin
      m_phase = 0; model_clear();
      m_valid = 0; m_data = 0; m_err = 0;
      return;
    end
    m_valid = rd_req;
    if (rd_req) begin
      model_read(int'(rd_sel), int'(rd_idx), d, e);
      m_data = d; m_err = e;
    end
    if (start) begin
      model_clear(); m_phase = 1;
    end else if (m_phase == 1) begin
      m_cyc = sat(m_cyc + 1);
      for (int i = 0; i < PE; i++) begin
        m_stall[i] = sat(m_stall[i] + int'(pe_stall[i]));
        m_conf[i]  = sat(m_conf[i] + int'(router_conflict[i]));
        if (!m_done_seen[i] && (pe_done[i] || layer_finished)) begin
          m_done_seen[i] = 1; m_fin[i] = m_cyc;
        end
      end
      if (layer_finished) m_phase = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("measuring", int'(measuring), int'(m_phase == 1));
    chk("stats_ready", int'(stats_ready), int'(m_phase == 2));
    chk("rd_valid", int'(rd_valid), m_valid);
    chk("rd_data", int'(rd_data), m_data);
    chk("rd_err", int'(rd_err), m_err);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_read(input int sel, input int idx);
    rd_req = 1'b1; rd_sel = 2'(sel); rd_idx = IW'(idx);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    m_phase = 0; m_valid = 0; m_data = 0; m_err = 0;
    model_clear();

    // Reset state
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_measuring", int'(measuring), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    do_read(3, 0);
    chk("rst_total", int'(rd_data), 0);

    // Stall count and total cycles
    do_start();
    for (int c = 1; c <= 10; c++) begin
      pe_stall[0] = (c == 2 || c == 3 || c == 7);
      layer_finished = (c == 10);
      tick();
    end
    pe_stall = '0; layer_finished = 1'b0;
    do_read(0, 0); chk("t1_stall0", int'(rd_data), 3);
    do_read(3, 0); chk("t1_total", int'(rd_data), 10);
    chk("t1_ready", int'(stats_ready), 1);

    // Finish capture
    do_start();
    for (int c = 1; c <= 9; c++) begin
      pe_done[1] = (c >= 4);
      layer_finished = (c == 9);
      tick();
    end
    pe_done = '0; layer_finished = 1'b0;
    do_read(2, 0); chk("t2_fin0", int'(rd_data), 9);
    do_read(2, 1); chk("t2_fin1", int'(rd_data), 4);
    do_read(2, 2); chk("t2_fin2", int'(rd_data), 9);
    do_read(2, 3); chk("t2_fin3", int'(rd_data), 9);

    // Saturation
    do_start();
    pe_stall[2] = 1'b1;
    repeat (20) tick();
    pe_stall = '0; layer_finished = 1'b1; tick(); layer_finished = 1'b0;
    do_read(0, 2); chk("t3_sat_stall", int'(rd_data), MAXV);
    do_read(3, 0); chk("t3_sat_total", int'(rd_data), MAXV);

    // Out-of-range index
    do_read(1, 12);
    chk("t4_oor_valid", int'(rd_valid), 1);
    chk("t4_oor_data", int'(rd_data), 0);
    chk("t4_oor_err", int'(rd_err), 1);
    do_read(1, 3);
`ifdef NOC_STATS_CONFLICT_EN
    chk("t4_sel1_err", int'(rd_err), 0);
`else
    chk("t4_sel1_err", int'(rd_err), 1);
`endif

    // Restart with concurrent read
    do_start();
    for (int c = 1; c <= 5; c++) begin
      router_conflict[3] = 1'b1; tick();
    end
    router_conflict = '0;
    start = 1'b1; rd_req = 1'b1; rd_sel = 2'd1; rd_idx = IW'(3);
    tick();
    start = 1'b0; rd_req = 1'b0;
`ifdef NOC_STATS_CONFLICT_EN
    chk("t5_preclear", int'(rd_data), 5);
`else
    chk("t5_preclear_err", int'(rd_err), 1);
`endif
    do_read(1, 3); chk("t5_cleared", int'(rd_data), 0);
    chk("t5_measuring", int'(measuring), 1);

    // Reset mid-run
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_measuring", int'(measuring), 0);
    chk("t6_valid", int'(rd_valid), 0);
    do_read(3, 0); chk("t6_total", int'(rd_data), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 299) == 0);
      start           = ($urandom_range(0, 39) == 0);
      pe_stall        = PE'($urandom);
      router_conflict = PE'($urandom);
      pe_done         = PE'($urandom & $urandom & $urandom);
      layer_finished  = ($urandom_range(0, 24) == 0);
      rd_req          = 1'($urandom);
      rd_sel          = 2'($urandom);
      rd_idx          = IW'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; rd_req = 1'b0; layer_finished = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
